// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - handshaked ALU front end with iterative shift-add MUL
// Define ALU_SEQ_MUL_EN to build the MUL state; otherwise opcode 6 is reported as illegal.
module alu_seq_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_opcode,
  input  logic [N-1:0] req_op_a,
  input  logic [N-1:0] req_op_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_err,
  output logic         busy
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_LESS = 4'd1;
  localparam logic [3:0] OP_EQ   = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_SEQ_MUL_EN
    MUL  = 2'd1,
`endif
    RESP = 2'd2
  } state_t;

  state_t state, state_d;

  logic         accept;
  logic         is_mul;
  logic [N-1:0] alu_res;
  logic         alu_err;
  logic [N-1:0] result_q;
  logic         err_q;

  assign accept     = req_valid && (state == IDLE);
  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);
  assign rsp_result = result_q;
  assign rsp_err    = err_q;

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  acc, acc_next, mcand, mplier;
  logic [CW-1:0] cnt;

  assign is_mul   = (req_opcode == OP_MUL);
  assign acc_next = mplier[0] ? (acc + mcand) : acc;
`else
  assign is_mul = 1'b0;
`endif

  // Single-cycle operations; MUL is only evaluated here when it is not built.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (req_opcode)
      OP_ADD:  alu_res = req_op_a + req_op_b;
      OP_LESS: alu_res = {{(N-1){1'b0}}, (req_op_a < req_op_b)};
      OP_EQ:   alu_res = {{(N-1){1'b0}}, (req_op_a == req_op_b)};
      OP_OR:   alu_res = req_op_a | req_op_b;
      OP_AND:  alu_res = req_op_a & req_op_b;
      OP_NOT:  alu_res = ~req_op_a;
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:  alu_res = '0;
`endif
      OP_SHR:  alu_res = req_op_a >> 1;
      OP_SHL:  alu_res = req_op_a << 1;
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
`ifdef ALU_SEQ_MUL_EN
      IDLE: if (accept) state_d = is_mul ? MUL : RESP;
      MUL:  if (cnt == CW'(1)) state_d = RESP;
`else
      IDLE: if (accept) state_d = RESP;
`endif
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result/err are written only at accept or MUL completion, so they hold during RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (accept && !is_mul) begin
      result_q <= alu_res;
      err_q    <= alu_err;
    end
`ifdef ALU_SEQ_MUL_EN
    else if (accept && is_mul) begin
      err_q <= 1'b0;
    end else if ((state == MUL) && (cnt == CW'(1))) begin
      result_q <= acc_next;
    end
`endif
  end

`ifdef ALU_SEQ_MUL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept && is_mul) begin
      acc    <= '0;
      mcand  <= req_op_a;
      mplier <= req_op_b;
      cnt    <= CW'(N);
    end else if (state == MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - directed self-checking bench for alu_seq_unit
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_opcode;
  logic [31:0] req_op_a;
  logic [31:0] req_op_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  alu_seq_unit #(.N(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_op_a   (req_op_a),
    .req_op_b   (req_op_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Drive one request from an IDLE cycle; extra = edges after the accept edge until rsp_valid.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int extra, output bit hold_ok);
    req_opcode = op;
    req_op_a   = a;
    req_op_b   = b;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_opcode = 4'd0;
    req_op_a   = $urandom;
    req_op_b   = $urandom;
    extra   = 0;
    hold_ok = 1'b1;
    while (!rsp_valid && extra < 100) begin
      if (req_ready || !busy) hold_ok = 1'b0;
      @(posedge clk); #1;
      extra++;
    end
    if (req_ready || !busy) hold_ok = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_opcode = 4'd0; req_op_a = '0; req_op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rsp_result !== 32'd0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_result got=%h/%b exp=0/0", rsp_result, rsp_err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_cycle();
    logic [3:0]  ops  [15];
    logic [31:0] as   [15];
    logic [31:0] bs   [15];
    logic [31:0] exps [15];
    logic        eerr [15];
    string       nm   [15];
    int          extra;
    bit          hold_ok;
    ops  = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd7, 4'd8, 4'd12, 4'd15};
    as   = '{32'd15, 32'hFFFFFFFF, 32'd5, 32'd10, 32'd20, 32'd20, 32'hA5A5A5A5, 32'hFFFF0000,
             32'hF0F0F0F0, 32'd10, 32'd10, 32'd1, 32'h80000001, 32'd7, 32'd3};
    bs   = '{32'd10, 32'd2, 32'd10, 32'd5, 32'd20, 32'd21, 32'h5A5A5A5A, 32'h0000FFFF,
             32'h12345678, 32'd0, 32'd0, 32'd0, 32'd0, 32'd9, 32'd4};
    exps = '{32'd25, 32'd1, 32'd1, 32'd0, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd0,
             32'h0F0F0F0F, 32'd5, 32'd20, 32'd0, 32'd2, 32'd0, 32'd0};
    eerr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    nm   = '{"add_15_10", "add_wrap", "less_5_10", "less_10_5", "eq_20_20", "eq_20_21", "or",
             "and", "not", "shr_10", "shl_10", "shr_1", "shl_msb", "illegal_12", "illegal_15"};
    for (int i = 0; i < 15; i++) begin
      issue(ops[i], as[i], bs[i], extra, hold_ok);
      checks++; if (rsp_result !== exps[i]) begin
        errors++; $display("FAIL %s result got=%h exp=%h", nm[i], rsp_result, exps[i]);
      end
      checks++; if (rsp_err !== eerr[i]) begin
        errors++; $display("FAIL %s err got=%b exp=%b", nm[i], rsp_err, eerr[i]);
      end
      checks++; if (extra !== 0 || !hold_ok) begin
        errors++; $display("FAIL %s latency got=%0d/%b exp=0/1", nm[i], extra, hold_ok);
      end
      consume();
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++; $display("FAIL %s consume got valid=%b ready=%b exp 0/1", nm[i], rsp_valid, req_ready);
      end
    end
  endtask

  task automatic test_mul();
    logic [31:0] as   [3];
    logic [31:0] bs   [3];
    logic [31:0] exps [3];
    logic        eerr;
    int          elat;
    int          extra;
    bit          hold_ok;
    as = '{32'd5, 32'h00010000, 32'hFFFFFFFF};
    bs = '{32'd10, 32'h00010000, 32'hFFFFFFFF};
`ifdef ALU_SEQ_MUL_EN
    exps = '{32'd50, 32'd0, 32'd1};
    eerr = 1'b0;
    elat = 32;
`else
    exps = '{32'd0, 32'd0, 32'd0};
    eerr = 1'b1;
    elat = 0;
`endif
    for (int i = 0; i < 3; i++) begin
      issue(4'd6, as[i], bs[i], extra, hold_ok);
      checks++; if (rsp_result !== exps[i] || rsp_err !== eerr) begin
        errors++; $display("FAIL mul_%0d result got=%h/%b exp=%h/%b", i, rsp_result, rsp_err, exps[i], eerr);
      end
      checks++; if (extra !== elat || !hold_ok) begin
        errors++; $display("FAIL mul_%0d latency got=%0d/%b exp=%0d/1", i, extra, hold_ok, elat);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int  extra;
    bit  hold_ok;
    bit  stable;
    issue(4'd0, 32'd3, 32'd4, extra, hold_ok);
    req_opcode = 4'd0; req_op_a = 32'd100; req_op_b = 32'd1; req_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== 32'd7 || rsp_err !== 1'b0)
        stable = 1'b0;
      @(posedge clk); #1;
    end
    checks++; if (!stable || rsp_result !== 32'd7) begin
      errors++; $display("FAIL bp_stall got result=%h stable=%b exp result=7 stable=1", rsp_result, stable);
    end
    consume();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got valid=%b ready=%b exp 0/1", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd101) begin
      errors++; $display("FAIL bp_second got valid=%b result=%h exp 1/%h", rsp_valid, rsp_result, 32'd101);
    end
    consume();
  endtask

  task automatic test_reset_mid_op();
    int  extra;
    bit  hold_ok;
    bit  saw_valid;
    req_opcode = 4'd6; req_op_a = 32'd5; req_op_b = 32'd10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_op got ready=%b valid=%b busy=%b exp 1/0/0", req_ready, rsp_valid, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) saw_valid = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (saw_valid) begin
      errors++; $display("FAIL rst_dropped got rsp_valid=1 exp=0");
    end
    issue(4'd0, 32'd1, 32'd1, extra, hold_ok);
    checks++; if (rsp_result !== 32'd2 || extra !== 0) begin
      errors++; $display("FAIL rst_then_add got=%h lat=%0d exp=2 lat=0", rsp_result, extra);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_backpressure();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

- Registered, handshaked front end for the team's N-bit ALU operation set.
- Accepts one operation per request on a valid/ready interface and holds the registered result on a valid/ready response interface until it is consumed.
- MUL runs as an iterative shift-add over N cycles; all other operations complete in one cycle.
- Sits between a command sequencer (or bench driver) and the datapath, replacing direct combinational opcode/op_a/op_b/result wiring.

## Interface
Parameters:
- N, 32, operand and result width (N ≥ 2)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, asynchronous and active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_opcode  in  4  operation select
- req_op_a  in  N  operand A
- req_op_b  in  N  operand B
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_result  out  N  registered result
- rsp_err  out  1  illegal opcode flag, qualified by rsp_valid
- busy  out  1  high in MUL or RESP

## Operation
- States: IDLE, MUL, RESP. Reset enters IDLE.
- A request is accepted when req_valid && req_ready. Operands and opcode are captured at that edge; later input changes are ignored.
- Opcode encodings and results (ADD wraps modulo 2^N, comparisons unsigned):
  - 0 ADD: A+B
  - 1 LESS: {0…, A<B}
  - 2 EQ: {0…, A==B}
  - 3 OR: A|B
  - 4 AND: A&B
  - 5 NOT: ~A, B ignored
  - 6 MUL: low N bits of A*B
  - 7 SHR: A>>1, zero fill
  - 8 SHL: A<<1, zero fill
- Opcodes 9–15 are illegal: rsp_result=0, rsp_err=1. No other case sets rsp_err.
- Transitions:
  - IDLE→RESP on accept of any non-MUL opcode. The result is written at the accept edge.
  - IDLE→MUL on accept of MUL. The accumulator is cleared and the bit counter is loaded with N.
  - MUL: each edge, if the multiplier LSB is 1, add the multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right, and decrement the counter. At the edge where the counter reaches 0, go to RESP with the accumulator in rsp_result.
  - RESP→IDLE on rsp_valid && rsp_ready.
- In RESP, rsp_result and rsp_err are held stable while rsp_ready is low.
- req_ready is low in MUL and RESP. There is no pipelining and no request queue.

## Timing
- Reset values: rsp_valid=0, rsp_result=0, rsp_err=0, busy=0, state=IDLE, so req_ready=1.
- Non-MUL latency: accept at edge k, rsp_valid high after edge k.
- MUL latency: accept at edge k, rsp_valid high after edge k+N.
- Response consumed at edge m: rsp_valid low and req_ready high after edge m. A new request can be accepted at edge m+1, giving a peak throughput of one operation per 2 cycles.
- req_valid held high while req_ready is low is not an accept. The request waits.
- A response that is never consumed stalls the unit indefinitely with outputs stable.
- Reset asserted mid-MUL or mid-RESP immediately returns to IDLE. The in-flight operation is dropped and no response is produced.
- rsp_valid is never asserted in the same cycle as req_ready.

## Configuration
- Macro ALU_SEQ_MUL_EN.
- Defined: MUL (opcode 6) behaves as specified above, with the MUL state present.
- Undefined: the MUL state and multiplier datapath are not built. Opcode 6 is treated as illegal (IDLE→RESP, result 0, rsp_err=1, latency 1).

## Test plan
- Reset then ADD 15+10 → rsp_valid 1 cycle after accept, result 25, err 0. ADD 0xFFFFFFFF+2 → 1.
- LESS 5,10 → 1; LESS 10,5 → 0; EQ 20,20 → 1; OR 0xA5A5A5A5|0x5A5A5A5A → 0xFFFFFFFF; AND 0xFFFF0000&0x0000FFFF → 0; NOT 0xF0F0F0F0 → 0x0F0F0F0F.
- With ALU_SEQ_MUL_EN: MUL 5×10 → 50 after exactly 32 cycles with busy high and req_ready low throughout. MUL 0x10000×0x10000 → 0. Without the macro: MUL → result 0, err 1, latency 1.
- SHR 10 → 5; SHL 10 → 20; opcode 7 with A=1 → 0; opcode 12 → result 0, err 1.
- Backpressure: hold rsp_ready low for 5 cycles after the response appears → result stable, req_ready low, second request not accepted; release → accepted the cycle after consumption.
- Assert rst mid-MUL (cycle 10) → rsp_valid never rises for that op, req_ready=1 immediately. Next ADD 1+1 → 2.
